// File: rtl/manchester_2_nrz_decoder_if.sv
// Line-side bundle of the Manchester decoder: serial input plus the recovered
// NRZ bit, its strobe and the lock/violation status.
interface manchester_2_nrz_decoder_if;
    logic M_in;
    logic B_out;
    logic B_valid;
    logic locked;
    logic code_err;

    modport master (output M_in, input B_out, B_valid, locked, code_err);
    modport slave  (input M_in, output B_out, B_valid, locked, code_err);
endinterface

// File: rtl/manchester_2_nrz_decoder.sv
// Manchester-to-NRZ decoder: synchronises the line, locks onto an alternating
// preamble, then decodes each bit from the direction of its mid-bit edge.
module manchester_2_nrz_decoder #(
    parameter int OSR        = 8,
    parameter int LOCK_EDGES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    manchester_2_nrz_decoder_if.slave  line
);
    localparam int CW = $clog2(2 * OSR);
    localparam int QW = $clog2(LOCK_EDGES + 1);

    localparam logic [CW-1:0] EARLY     = CW'(3 * OSR / 4);
    localparam logic [CW-1:0] LATE      = CW'(5 * OSR / 4);
    localparam logic [CW-1:0] CNT_MAX   = CW'(2 * OSR - 1);
    localparam logic [QW-1:0] QUAL_LOCK = QW'(LOCK_EDGES);

    localparam logic [0:0] HUNT  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    logic          s1, s2, s3;
    logic [CW-1:0] cnt;
    logic [QW-1:0] qual;
    logic          bnd;
    logic [0:0]    state;
    logic          b_out_r, b_valid_r, locked_r, code_err_r;

    logic          edge_det, fall, early, in_win;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CW'(1);
    endfunction

    // Stage boundary: s2/s3 are the synchronised line; edges are seen one clock after s2
    assign edge_det = s2 ^ s3;
    assign fall     = s3 & ~s2;
    assign early    = (cnt < EARLY);
    assign in_win   = (cnt >= EARLY) && (cnt <= LATE);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            qual       <= '0;
            bnd        <= 1'b0;
            state      <= HUNT;
            b_out_r    <= 1'b0;
            b_valid_r  <= 1'b0;
            locked_r   <= 1'b0;
            code_err_r <= 1'b0;
        end else begin
            s1         <= line.M_in;
            s2         <= s1;
            s3         <= s2;
            b_valid_r  <= 1'b0;
            code_err_r <= 1'b0;
            cnt        <= sat_inc(cnt);

            if (state == HUNT) begin
                if (edge_det) begin
                    cnt <= CW'(1);
                    if (in_win) begin
                        qual <= qual + QW'(1);
                        // The edge that completes qualification only locks; it carries no bit
                        if (qual + QW'(1) == QUAL_LOCK) begin
                            state    <= TRACK;
                            locked_r <= 1'b1;
                            bnd      <= 1'b0;
                        end
                    end else begin
                        qual <= '0;
                    end
                end
            end else begin
                if (edge_det && in_win) begin
                    b_out_r   <= fall;
                    b_valid_r <= 1'b1;
                    cnt       <= CW'(1);
                    bnd       <= 1'b0;
                end else if (edge_det && early && !bnd) begin
                    bnd <= 1'b1;
                end else if (edge_det || (cnt == LATE)) begin
                    // Second early edge, or mid-bit edge missing by the end of the window
                    code_err_r <= 1'b1;
                    locked_r   <= 1'b0;
                    state      <= HUNT;
                    qual       <= '0;
                    cnt        <= '0;
                    b_valid_r  <= 1'b0;
                end
            end
        end
    end

    assign line.B_out    = b_out_r;
    assign line.B_valid  = b_valid_r;
    assign line.locked   = locked_r;
    assign line.code_err = code_err_r;

endmodule

// File: tb/tb_manchester_2_nrz_decoder.sv
// Scoreboard bench for the Manchester decoder: stimulus pushes expected lock,
// bit and error events with their cycle; a monitor pops and compares them.
module tb_manchester_2_nrz_decoder;
    localparam int OSR     = 8;
    localparam int HALF    = OSR / 2;
    localparam int EV_NONE = -1;
    localparam int EV_LOCK = 0;
    localparam int EV_BIT  = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } evt_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic lvl   = 1'b1;
    logic locked_q = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   last  = 0;
    evt_t sb[$];

    manchester_2_nrz_decoder_if line ();

    manchester_2_nrz_decoder #(.OSR(OSR), .LOCK_EDGES(4)) dut (
        .clock (clock),
        .reset (reset),
        .line  (line)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int want);
        total++;
        if (obs != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    task automatic push_evt(input int kind, input int val, input int at);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input int val);
        evt_t e;
        check_val("evt_pending", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("evt_kind", kind, e.kind);
            check_val("evt_cycle", cyc, e.cyc);
            check_val("evt_bit", val, e.val);
        end
    endtask

    // One line sample per clock; the value is registered into s1 on the next edge
    task automatic drive();
        line.M_in = lvl;
        @(posedge clock);
        #1;
    endtask

    task automatic hold_to(input int t);
        while (cyc < t) drive();
    endtask

    // Bit b with its mid-bit flip driven at cycle mid; decoded 3 edges later
    task automatic put_bit(input logic b, input int mid, input int mode);
        hold_to(mid - HALF);
        lvl = b;
        hold_to(mid);
        lvl = ~b;
        if (mode == EV_LOCK) push_evt(EV_LOCK, 0, mid + 3);
        else if (mode == EV_BIT) push_evt(EV_BIT, int'(b), mid + 3);
        drive();
    endtask

    task automatic preamble(output int mid_last);
        int start;
        start = cyc + OSR;
        for (int i = 0; i < 5; i++)
            put_bit((i % 2) == 0, start + i * OSR, (i == 4) ? EV_LOCK : EV_NONE);
        mid_last = start + 4 * OSR;
    endtask

    task automatic data_bit(input logic b, input int spacing, inout int mid_last);
        mid_last = mid_last + spacing;
        put_bit(b, mid_last, EV_BIT);
    endtask

    always @(negedge clock) begin
        if (line.locked && !locked_q) expect_evt(EV_LOCK, 0);
        if (line.B_valid) expect_evt(EV_BIT, int'(line.B_out));
        if (line.code_err) begin
            expect_evt(EV_ERR, 0);
            check_val("err_unlocks", int'(line.locked), 0);
            check_val("err_no_valid", int'(line.B_valid), 0);
        end
        locked_q = line.locked;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d want finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        line.M_in = 1'b1;
        reset = 1'b1;
        lvl   = 1'b1;
        repeat (3) drive();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive();
            check_val("idle_outs",
                      int'({line.B_out, line.B_valid, line.locked, line.code_err}), 0);
        end

        // Lock then decode 1,1,0,0,1
        preamble(last);
        data_bit(1'b1, OSR, last);
        data_bit(1'b1, OSR, last);
        data_bit(1'b0, OSR, last);
        data_bit(1'b0, OSR, last);
        data_bit(1'b1, OSR, last);

        // Jitter within the window, then one edge too late
        data_bit(1'b0, 6, last);
        data_bit(1'b1, 10, last);
        data_bit(1'b0, 8, last);
        push_evt(EV_ERR, 0, last + 13);
        put_bit(1'b1, last + 11, EV_NONE);
        hold_to(cyc + 20);

        // Missing transition
        preamble(last);
        data_bit(1'b0, OSR, last);
        data_bit(1'b1, OSR, last);
        push_evt(EV_ERR, 0, last + 13);
        hold_to(last + 17);
        hold_to(cyc + 10);

        // Glitch: two early edges at cnt 3 and 4
        preamble(last);
        data_bit(1'b1, OSR, last);
        data_bit(1'b0, OSR, last);
        hold_to(last + 3);
        lvl = ~lvl;
        drive();
        lvl = ~lvl;
        push_evt(EV_ERR, 0, last + 7);
        drive();
        hold_to(cyc + 20);

        // Re-lock after the glitch, then reset during the 3rd data bit
        preamble(last);
        data_bit(1'b1, OSR, last);
        data_bit(1'b0, OSR, last);
        last = last + OSR;
        put_bit(1'b1, last, EV_NONE);
        reset = 1'b1;
        drive();
        reset = 1'b0;
        check_val("rst_B_out", int'(line.B_out), 0);
        check_val("rst_B_valid", int'(line.B_valid), 0);
        check_val("rst_locked", int'(line.locked), 0);
        check_val("rst_code_err", int'(line.code_err), 0);
        put_bit(1'b1, last + OSR, EV_NONE);
        hold_to(cyc + 20);

        preamble(last);
        data_bit(1'b0, OSR, last);
        data_bit(1'b1, OSR, last);
        data_bit(1'b1, OSR, last);
        push_evt(EV_ERR, 0, last + 13);
        hold_to(last + 30);

        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
